// File: rtl/spi_slave.sv
// spi_slave: SPI responder sampled in the system clock domain, all CPOL/CPHA modes, MSB/LSB first.
// Optional overrun flag is built when SPI_SLAVE_OVERRUN_EN is defined.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_sck,
    input  logic                  i_ss,
    input  logic                  i_mosi,
    output logic                  o_miso,
    output logic                  o_miso_oe,
    input  logic [2:0]            i_data_config,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_load,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_interrupt,
    input  logic                  i_int_clr,
    output logic                  o_overrun
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t r_state;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    logic r_sck_d;
    logic r_ss_d;
    logic r_sck_rise;
    logic r_sck_fall;
    logic r_ss_fall;
    logic r_ss_rise;
    logic r_mosi_q;

    logic r_cpha;
    logic r_cpol;
    logic r_lsb;

    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_tx_ready;
    logic                  r_rx_valid;
    logic                  r_interrupt;
    logic                  r_miso;
    logic                  r_miso_oe;

    logic                  w_sck;
    logic                  w_ss;
    logic                  w_mosi;
    logic                  w_lead;
    logic                  w_trail;
    logic                  w_sample;
    logic                  w_shift;
    logic                  w_last;
    logic                  w_consume;
    logic                  w_load_acc;
    logic                  w_first_cfg;
    logic                  w_first_cur;
    logic                  w_next_bit;
    logic [DATA_WIDTH-1:0] w_rx_next;
    logic [DATA_WIDTH-1:0] w_tx_shifted;

    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_ss   = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // Sync flops reset low so SS held low through reset never looks like a fresh fall.
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst) begin
            r_sck_sync  <= '0;
            r_ss_sync   <= '0;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_ss_d      <= 1'b0;
            r_sck_rise  <= 1'b0;
            r_sck_fall  <= 1'b0;
            r_ss_fall   <= 1'b0;
            r_ss_rise   <= 1'b0;
            r_mosi_q    <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sck_d     <= w_sck;
            r_ss_d      <= w_ss;
            r_sck_rise  <= w_sck & ~r_sck_d;
            r_sck_fall  <= ~w_sck & r_sck_d;
            r_ss_fall   <= ~w_ss & r_ss_d;
            r_ss_rise   <= w_ss & ~r_ss_d;
            r_mosi_q    <= w_mosi;
        end
    end

    assign w_lead   = r_cpol ? r_sck_fall : r_sck_rise;
    assign w_trail  = r_cpol ? r_sck_rise : r_sck_fall;
    assign w_sample = r_cpha ? w_trail : w_lead;
    assign w_shift  = r_cpha ? w_lead : w_trail;
    assign w_last   = (r_cnt == CW'(DATA_WIDTH - 1));

    assign w_rx_next = r_lsb ? {r_mosi_q, r_rx_shift[DATA_WIDTH-1:1]}
                             : {r_rx_shift[DATA_WIDTH-2:0], r_mosi_q};

    assign w_tx_shifted = r_lsb ? {1'b0, r_tx_shift[DATA_WIDTH-1:1]}
                                : {r_tx_shift[DATA_WIDTH-2:0], 1'b0};

    assign w_next_bit  = r_lsb ? r_tx_shift[1] : r_tx_shift[DATA_WIDTH-2];
    assign w_first_cfg = i_data_config[2] ? r_hold[0] : r_hold[DATA_WIDTH-1];
    assign w_first_cur = r_lsb ? r_hold[0] : r_hold[DATA_WIDTH-1];

    // A shift edge with the counter at zero starts a new word (reload instead of shift).
    assign w_consume =
        ((r_state == ST_IDLE) && r_ss_fall && !i_data_config[0]) ||
        ((r_state == ST_ACTIVE) && !r_ss_rise && w_shift && (r_cnt == '0));

    assign w_load_acc = i_tx_load & r_tx_ready;

`ifdef SPI_SLAVE_OVERRUN_EN
    logic r_overrun;
    assign o_overrun = r_overrun;
`else
    assign o_overrun = 1'b0;
`endif

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst) begin
            r_state     <= ST_IDLE;
            r_cpha      <= 1'b0;
            r_cpol      <= 1'b0;
            r_lsb       <= 1'b0;
            r_cnt       <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_hold      <= '0;
            r_rx_data   <= '0;
            r_tx_ready  <= 1'b1;
            r_rx_valid  <= 1'b0;
            r_interrupt <= 1'b0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            r_overrun   <= 1'b0;
`endif
        end else begin
            r_rx_valid <= 1'b0;
            if (i_int_clr) begin
                r_interrupt <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
                r_overrun   <= 1'b0;
`endif
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (r_ss_fall) begin
                        r_state    <= ST_ACTIVE;
                        r_miso_oe  <= 1'b1;
                        r_cpha     <= i_data_config[0];
                        r_cpol     <= i_data_config[1];
                        r_lsb      <= i_data_config[2];
                        r_cnt      <= '0;
                        r_rx_shift <= '0;
                        if (!i_data_config[0]) begin
                            r_tx_shift <= r_hold;
                            r_miso     <= w_first_cfg;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (r_ss_rise) begin
                        r_state    <= ST_IDLE;
                        r_miso_oe  <= 1'b0;
                        r_miso     <= 1'b0;
                        r_cnt      <= '0;
                        r_rx_shift <= '0;
                    end else begin
                        if (w_sample) begin
                            r_rx_shift <= w_rx_next;
                            if (w_last) begin
                                r_cnt       <= '0;
                                r_rx_data   <= w_rx_next;
                                r_rx_valid  <= 1'b1;
                                r_interrupt <= 1'b1;
`ifdef SPI_SLAVE_OVERRUN_EN
                                if (r_interrupt) begin
                                    r_overrun <= 1'b1;
                                end
`endif
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                        if (w_shift) begin
                            if (r_cnt == '0) begin
                                r_tx_shift <= r_hold;
                                r_miso     <= w_first_cur;
                            end else begin
                                r_tx_shift <= w_tx_shifted;
                                r_miso     <= w_next_bit;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // An accepted load leaves fresh data pending even if the old word is consumed now.
            if (w_load_acc) begin
                r_hold     <= i_tx_data;
                r_tx_ready <= 1'b0;
            end else if (w_consume) begin
                r_tx_ready <= 1'b1;
            end
        end
    end

    assign o_miso      = r_miso;
    assign o_miso_oe   = r_miso_oe;
    assign o_tx_ready  = r_tx_ready;
    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_interrupt = r_interrupt;

endmodule

// File: doc/spi_slave.md
# spi_slave

Synchronous SPI slave: the responder end of the bus that `spi_module` drives as master. It samples the master's SCK, SS and MOSI in the system clock domain, shifts received bits into a parallel word, and returns a pre-loaded transmit word on MISO. It supports all four CPOL/CPHA modes plus MSB/LSB-first order. A completed frame raises an interrupt towards the local host.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: frame length in bits.
- `SYNC_STAGES`, default 2, minimum 2: synchronizer depth on SCK, SS and MOSI.

Ports:
- `i_sys_clk` in 1: system clock.
- `i_sys_rst` in 1: reset, synchronous and active-low.
- `i_sck` in 1: bus clock from the master.
- `i_ss` in 1: slave select, active-low.
- `i_mosi` in 1: master-out data.
- `o_miso` out 1: slave-out data.
- `o_miso_oe` out 1: MISO output enable. High while the synchronized SS is low.
- `i_data_config` in 3: bit0 CPHA, bit1 CPOL, bit2 LSB-first.
- `i_tx_data` in DATA_WIDTH: transmit word.
- `i_tx_load` in 1: write `i_tx_data` into the holding register.
- `o_tx_ready` out 1: holding register empty. Loads are accepted only when this is 1.
- `o_rx_data` out DATA_WIDTH: last complete received word.
- `o_rx_valid` out 1: one-cycle pulse when `o_rx_data` updates.
- `o_interrupt` out 1: sticky frame-done flag.
- `i_int_clr` in 1: clears `o_interrupt`.
- `o_overrun` out 1: see Configuration.

## Operation
- Synchronizers: SCK, SS and MOSI each pass through SYNC_STAGES flops. SCK edges are detected from the last two synchronized SCK samples.
- Edge roles:
  - Leading edge is rising when CPOL=0, falling when CPOL=1.
  - CPHA=0: sample on the leading edge, shift on the trailing edge.
  - CPHA=1: shift on the leading edge, sample on the trailing edge.
- Configuration is latched when synchronized SS falls. Changes mid-frame are ignored.
- FSM states: IDLE, ACTIVE.
  - IDLE → ACTIVE on synchronized SS falling.
  - ACTIVE → IDLE on synchronized SS rising.
- Shift register load from the holding register. Each load sets `o_tx_ready`=1.
  - CPHA=0: load at the SS fall, so the first bit is on MISO before the first edge. Reload on the trailing edge that follows the final sample.
  - CPHA=1: load on the first leading edge of each frame.
- A holding register that has not been refreshed still supplies its current value; it is not cleared after consumption.
- Bit counter 0..DATA_WIDTH-1, increments on each sample edge.
  - At DATA_WIDTH-1 it wraps to 0.
  - On wrap: `o_rx_data` ← assembled word, `o_rx_valid` pulses, `o_interrupt` sets.
  - Back-to-back frames under one SS-low period are supported.
- Bit order: MSB first when bit2=0, LSB first when bit2=1. Applies to both MOSI and MISO.
- `o_miso` is 0 while in IDLE.
- SS rising mid-frame (abort):
  - Counter → 0; partial word discarded.
  - No `o_rx_valid`, no interrupt.
  - Holding register unchanged.
- Simultaneous events:
  - `i_int_clr` in the same cycle as a frame completion: set wins.
  - `i_tx_load` while `o_tx_ready`=0 is ignored, including in the consumption cycle, because ready is a registered value.

## Timing
- Reset values:
  - `o_miso`=0, `o_miso_oe`=0, `o_tx_ready`=1.
  - `o_rx_data`=0, `o_rx_valid`=0, `o_interrupt`=0, `o_overrun`=0.
  - Holding and shift registers =0; FSM in IDLE.
- Internal edge detect occurs SYNC_STAGES+1 cycles after an SCK pin edge.
- `o_rx_valid` asserts SYNC_STAGES+2 cycles after the final sample edge at the pin.
- `o_miso` updates SYNC_STAGES+2 cycles after a shift edge at the pin.
- `o_tx_ready` rises 1 cycle after the load edge is detected.
- SCK high and low phases must each be ≥ 2·(SYNC_STAGES+2) system clocks. With the default parameters, the SCK period is ≥ 16 system clocks.
- `i_sys_rst` low mid-frame returns all state to reset values on the next clock edge. The next frame starts only on a fresh SS fall.

## Configuration
- `SPI_SLAVE_OVERRUN_EN` defined:
  - `o_overrun` sets when a frame completes while `o_interrupt` is still 1.
  - It clears with `i_int_clr`; set wins over clear.
  - `o_rx_data` is still overwritten.
- Not defined: `o_overrun` is tied to 0 and no overrun logic is built.

## Test plan
- Mode 0, MSB first:
  - Stimulus: load 0xA5, master sends 0x3C.
  - Required: master receives 0xA5; `o_rx_data`=0x3C with a single `o_rx_valid` pulse; `o_interrupt`=1; `o_tx_ready` 0→1 at frame start.
- Modes 1, 2, 3, each with LSB-first on and off:
  - Stimulus: load 0x81, master sends 0x5A.
  - Required: correct words in both directions for every combination.
- Back-to-back frames:
  - Stimulus: 0x11 then 0x22 under one SS low, holding reloaded between frames.
  - Required: two `o_rx_valid` pulses; MISO carries both words.
- Abort:
  - Stimulus: SS raised after 5 bits.
  - Required: no `o_rx_valid`; `o_rx_data` unchanged; the next full frame is received correctly.
- Overrun (with `SPI_SLAVE_OVERRUN_EN`):
  - Stimulus: two frames without `i_int_clr`.
  - Required: `o_overrun`=1; `i_int_clr` clears both flags. Without the macro, `o_overrun` stays 0.
- Reset mid-frame:
  - Stimulus: `i_sys_rst` low after 3 bits.
  - Required: all outputs at reset values on the next clock edge.
